// File: rtl/tlb_op_unit_if.sv
// Bundle between the TLB maintenance sequencer, the commit stage and the MMU:
// request handshake, MMU strobes and responses, and the CSR write-back packet.
interface tlb_op_unit_if #(
  parameter int IDX_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_op_i;
  logic [4:0]       req_invop_i;
  logic [9:0]       req_asid_i;
  logic [18:0]      req_vpn_i;

  logic             tlbsrch_en_o;
  logic             tlbrd_en_o;
  logic             tlbwr_en_o;
  logic             tlbfill_en_o;
  logic             invtlb_en_o;
  logic [4:0]       invtlb_op_o;
  logic [9:0]       invtlb_asid_o;
  logic [18:0]      invtlb_vpn_o;
  logic [IDX_W-1:0] rand_idx_o;

  logic             tlbsrch_found_i;
  logic [IDX_W-1:0] tlbsrch_idx_i;
  logic [31:0]      tlbehi_i;
  logic [31:0]      tlbelo0_i;
  logic [31:0]      tlbelo1_i;
  logic [31:0]      tlbidx_i;
  logic [9:0]       tlbasid_i;

  logic             wb_valid_o;
  logic             wb_idx_we_o;
  logic             wb_ehi_we_o;
  logic             wb_elo_we_o;
  logic             wb_asid_we_o;
  logic [31:0]      wb_tlbidx_o;
  logic [31:0]      wb_tlbidx_mask_o;
  logic [31:0]      wb_tlbehi_o;
  logic [31:0]      wb_tlbelo0_o;
  logic [31:0]      wb_tlbelo1_o;
  logic [9:0]       wb_asid_o;

  logic             done_o;
  logic             refetch_o;
  logic             ine_o;

  modport master (
    output req_valid_i, req_op_i, req_invop_i, req_asid_i, req_vpn_i,
    output tlbsrch_found_i, tlbsrch_idx_i, tlbehi_i, tlbelo0_i, tlbelo1_i,
    output tlbidx_i, tlbasid_i,
    input  req_ready_o,
    input  tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o,
    input  invtlb_op_o, invtlb_asid_o, invtlb_vpn_o, rand_idx_o,
    input  wb_valid_o, wb_idx_we_o, wb_ehi_we_o, wb_elo_we_o, wb_asid_we_o,
    input  wb_tlbidx_o, wb_tlbidx_mask_o, wb_tlbehi_o, wb_tlbelo0_o,
    input  wb_tlbelo1_o, wb_asid_o,
    input  done_o, refetch_o, ine_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_invop_i, req_asid_i, req_vpn_i,
    input  tlbsrch_found_i, tlbsrch_idx_i, tlbehi_i, tlbelo0_i, tlbelo1_i,
    input  tlbidx_i, tlbasid_i,
    output req_ready_o,
    output tlbsrch_en_o, tlbrd_en_o, tlbwr_en_o, tlbfill_en_o, invtlb_en_o,
    output invtlb_op_o, invtlb_asid_o, invtlb_vpn_o, rand_idx_o,
    output wb_valid_o, wb_idx_we_o, wb_ehi_we_o, wb_elo_we_o, wb_asid_we_o,
    output wb_tlbidx_o, wb_tlbidx_mask_o, wb_tlbehi_o, wb_tlbelo0_o,
    output wb_tlbelo1_o, wb_asid_o,
    output done_o, refetch_o, ine_o
  );
endinterface

// File: rtl/tlb_op_unit.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: issues one MMU strobe per
// instruction, captures the MMU response and returns a masked CSR write-back.
module tlb_op_unit #(
  parameter int TLB_ENTRY_NUM = 32,
  parameter int RSP_LAT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  tlb_op_unit_if.slave bus
);
  localparam int IDX_W = $clog2(TLB_ENTRY_NUM);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [1:0]  WAIT_LAST   = 2'(RSP_LAT - 1);
  localparam logic [31:0] NE_BIT      = 32'h8000_0000;
  localparam logic [31:0] RD_IDX_MASK = 32'hBF00_0000;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [2:0]       r_op;
  logic [1:0]       r_wait_cnt;
  logic [IDX_W-1:0] r_rand_cnt;
  logic [IDX_W-1:0] r_rand_idx;

  logic        r_srch_en, r_rd_en, r_wr_en, r_fill_en, r_inv_en;
  logic [4:0]  r_inv_op;
  logic [9:0]  r_inv_asid;
  logic [18:0] r_inv_vpn;

  logic        r_wb_valid, r_idx_we, r_ehi_we, r_elo_we, r_asid_we;
  logic [31:0] r_wb_tlbidx, r_wb_mask, r_wb_ehi, r_wb_elo0, r_wb_elo1;
  logic [9:0]  r_wb_asid;
  logic        r_done, r_refetch, r_ine;

  logic        w_accept, w_illegal, w_capture, w_rd_op;
  logic [31:0] w_srch_mask;
  logic [31:0] w_wb_tlbidx, w_wb_mask, w_wb_ehi, w_wb_elo0, w_wb_elo1;
  logic [9:0]  w_wb_asid;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid_i;
  assign w_illegal = (bus.req_op_i > OP_INV) ||
                     ((bus.req_op_i == OP_INV) && (bus.req_invop_i > 5'd6));
  assign w_capture = (r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST);
  assign w_rd_op   = (r_op == OP_RD);

  // Search write-back touches NE always, and the index field only on a hit.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_srch_mask
      if (gi == 31) begin : g_ne
        assign w_srch_mask[gi] = 1'b1;
      end else if (gi < IDX_W) begin : g_idx
        assign w_srch_mask[gi] = bus.tlbsrch_found_i;
      end else begin : g_zero
        assign w_srch_mask[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_next = ((r_op == OP_SRCH) || w_rd_op) ? S_WAIT : S_RESP;
      S_WAIT:  if (w_capture) w_state_next = S_RESP;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wb_tlbidx = 32'h0;
    w_wb_mask   = 32'h0;
    w_wb_ehi    = 32'h0;
    w_wb_elo0   = 32'h0;
    w_wb_elo1   = 32'h0;
    w_wb_asid   = 10'h0;
    if (w_rd_op) begin
      w_wb_mask = RD_IDX_MASK;
      if (!bus.tlbidx_i[31]) begin
        w_wb_tlbidx = bus.tlbidx_i;
        w_wb_ehi    = bus.tlbehi_i;
        w_wb_elo0   = bus.tlbelo0_i;
        w_wb_elo1   = bus.tlbelo1_i;
        w_wb_asid   = bus.tlbasid_i;
      end else begin
        w_wb_tlbidx = NE_BIT;
      end
    end else begin
      w_wb_mask   = w_srch_mask;
      w_wb_tlbidx = bus.tlbsrch_found_i ? {{(32-IDX_W){1'b0}}, bus.tlbsrch_idx_i} : NE_BIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_SRCH;
      r_wait_cnt  <= 2'd0;
      r_rand_cnt  <= '0;
      r_rand_idx  <= '0;
      r_srch_en   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_fill_en   <= 1'b0;
      r_inv_en    <= 1'b0;
      r_inv_op    <= 5'h0;
      r_inv_asid  <= 10'h0;
      r_inv_vpn   <= 19'h0;
      r_wb_valid  <= 1'b0;
      r_idx_we    <= 1'b0;
      r_ehi_we    <= 1'b0;
      r_elo_we    <= 1'b0;
      r_asid_we   <= 1'b0;
      r_wb_tlbidx <= 32'h0;
      r_wb_mask   <= 32'h0;
      r_wb_ehi    <= 32'h0;
      r_wb_elo0   <= 32'h0;
      r_wb_elo1   <= 32'h0;
      r_wb_asid   <= 10'h0;
      r_done      <= 1'b0;
      r_refetch   <= 1'b0;
      r_ine       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rand_cnt <= r_rand_cnt + IDX_W'(1);
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;

      if (w_accept) r_op <= bus.req_op_i;
      if (w_accept && (bus.req_op_i == OP_FILL)) r_rand_idx <= r_rand_cnt;
      if (w_accept && !w_illegal && (bus.req_op_i == OP_INV)) begin
        r_inv_op   <= bus.req_invop_i;
        r_inv_asid <= bus.req_asid_i;
        r_inv_vpn  <= bus.req_vpn_i;
      end

      // Strobes are set on the accept edge so they are high for exactly the ISSUE cycle.
      r_srch_en <= w_accept && !w_illegal && (bus.req_op_i == OP_SRCH);
      r_rd_en   <= w_accept && !w_illegal && (bus.req_op_i == OP_RD);
      r_wr_en   <= w_accept && !w_illegal && (bus.req_op_i == OP_WR);
      r_fill_en <= w_accept && !w_illegal && (bus.req_op_i == OP_FILL);
      r_inv_en  <= w_accept && !w_illegal && (bus.req_op_i == OP_INV);

      r_wb_valid  <= w_capture;
      r_idx_we    <= w_capture;
      r_ehi_we    <= w_capture && w_rd_op;
      r_elo_we    <= w_capture && w_rd_op;
      r_asid_we   <= w_capture && w_rd_op;
      r_wb_tlbidx <= w_capture ? w_wb_tlbidx : 32'h0;
      r_wb_mask   <= w_capture ? w_wb_mask   : 32'h0;
      r_wb_ehi    <= w_capture ? w_wb_ehi    : 32'h0;
      r_wb_elo0   <= w_capture ? w_wb_elo0   : 32'h0;
      r_wb_elo1   <= w_capture ? w_wb_elo1   : 32'h0;
      r_wb_asid   <= w_capture ? w_wb_asid   : 10'h0;

      r_done    <= (w_state_next == S_RESP);
      r_ine     <= w_accept && w_illegal;
      r_refetch <= (r_state == S_ISSUE) &&
                   ((r_op == OP_WR) || (r_op == OP_FILL) || (r_op == OP_INV));
    end
  end

  assign bus.req_ready_o      = (r_state == S_IDLE);
  assign bus.tlbsrch_en_o     = r_srch_en;
  assign bus.tlbrd_en_o       = r_rd_en;
  assign bus.tlbwr_en_o       = r_wr_en;
  assign bus.tlbfill_en_o     = r_fill_en;
  assign bus.invtlb_en_o      = r_inv_en;
  assign bus.invtlb_op_o      = r_inv_op;
  assign bus.invtlb_asid_o    = r_inv_asid;
  assign bus.invtlb_vpn_o     = r_inv_vpn;
  assign bus.rand_idx_o       = r_rand_idx;
  assign bus.wb_valid_o       = r_wb_valid;
  assign bus.wb_idx_we_o      = r_idx_we;
  assign bus.wb_ehi_we_o      = r_ehi_we;
  assign bus.wb_elo_we_o      = r_elo_we;
  assign bus.wb_asid_we_o     = r_asid_we;
  assign bus.wb_tlbidx_o      = r_wb_tlbidx;
  assign bus.wb_tlbidx_mask_o = r_wb_mask;
  assign bus.wb_tlbehi_o      = r_wb_ehi;
  assign bus.wb_tlbelo0_o     = r_wb_elo0;
  assign bus.wb_tlbelo1_o     = r_wb_elo1;
  assign bus.wb_asid_o        = r_wb_asid;
  assign bus.done_o           = r_done;
  assign bus.refetch_o        = r_refetch;
  assign bus.ine_o            = r_ine;
endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit: one DUT with RSP_LAT=1 for the main flows and
// one with RSP_LAT=3 for the reset-during-WAIT case.
module tb_tlb_op_unit;
  logic clk;
  logic rst;
  logic rst_b;
  int   pass_cnt;
  int   total_cnt;

  tlb_op_unit_if #(.IDX_W(5)) ifa ();
  tlb_op_unit_if #(.IDX_W(5)) ifb ();

  tlb_op_unit #(.TLB_ENTRY_NUM(32), .RSP_LAT(1)) dut   (.clk(clk), .rst(rst),   .bus(ifa));
  tlb_op_unit #(.TLB_ENTRY_NUM(32), .RSP_LAT(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.req_valid_i = 0; ifa.req_op_i = 0; ifa.req_invop_i = 0; ifa.req_asid_i = 0; ifa.req_vpn_i = 0;
    ifa.tlbsrch_found_i = 0; ifa.tlbsrch_idx_i = 0; ifa.tlbehi_i = 0; ifa.tlbelo0_i = 0;
    ifa.tlbelo1_i = 0; ifa.tlbidx_i = 0; ifa.tlbasid_i = 0;
    ifb.req_valid_i = 0; ifb.req_op_i = 0; ifb.req_invop_i = 0; ifb.req_asid_i = 0; ifb.req_vpn_i = 0;
    ifb.tlbsrch_found_i = 0; ifb.tlbsrch_idx_i = 0; ifb.tlbehi_i = 0; ifb.tlbelo0_i = 0;
    ifb.tlbelo1_i = 0; ifb.tlbidx_i = 0; ifb.tlbasid_i = 0;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [4:0] invop,
                           input logic [9:0] asid, input logic [18:0] vpn);
    ifa.req_valid_i = 1; ifa.req_op_i = op; ifa.req_invop_i = invop;
    ifa.req_asid_i = asid; ifa.req_vpn_i = vpn;
  endtask

  task automatic test_reset();
    rst = 1; rst_b = 1;
    step();
    rst = 0; rst_b = 0;
    $display("txn reset");
    total_cnt++; if (ifa.req_ready_o !== 1'b1) $display("FAIL reset_ready: got %0h exp 1", ifa.req_ready_o); else pass_cnt++;
    total_cnt++; if ({ifa.tlbsrch_en_o, ifa.tlbrd_en_o, ifa.tlbwr_en_o, ifa.tlbfill_en_o, ifa.invtlb_en_o} !== 5'b0)
      $display("FAIL reset_strobes: got %0h exp 0", {ifa.tlbsrch_en_o, ifa.tlbrd_en_o, ifa.tlbwr_en_o, ifa.tlbfill_en_o, ifa.invtlb_en_o}); else pass_cnt++;
    total_cnt++; if ({ifa.done_o, ifa.refetch_o, ifa.ine_o, ifa.wb_valid_o} !== 4'b0)
      $display("FAIL reset_done: got %0h exp 0", {ifa.done_o, ifa.refetch_o, ifa.ine_o, ifa.wb_valid_o}); else pass_cnt++;
    total_cnt++; if ({ifa.rand_idx_o, ifa.invtlb_op_o, ifa.invtlb_asid_o, ifa.invtlb_vpn_o, ifa.wb_tlbidx_mask_o} !== '0)
      $display("FAIL reset_regs: got %0h exp 0", {ifa.rand_idx_o, ifa.invtlb_op_o, ifa.invtlb_asid_o, ifa.invtlb_vpn_o, ifa.wb_tlbidx_mask_o}); else pass_cnt++;
  endtask

  task automatic test_srch(input logic found, input logic [4:0] idx,
                           input logic [31:0] exp_idx, input logic [31:0] exp_mask);
    drive_req(3'd0, 5'd0, 10'd0, 19'd0);
    step();
    ifa.req_valid_i = 0;
    ifa.tlbsrch_found_i = ~found; ifa.tlbsrch_idx_i = ~idx;
    $display("txn srch found=%0d idx=%0d", found, idx);
    total_cnt++; if (ifa.tlbsrch_en_o !== 1'b1) $display("FAIL srch_strobe: got %0h exp 1", ifa.tlbsrch_en_o); else pass_cnt++;
    total_cnt++; if (ifa.req_ready_o !== 1'b0) $display("FAIL srch_ready_issue: got %0h exp 0", ifa.req_ready_o); else pass_cnt++;
    step();
    ifa.tlbsrch_found_i = found; ifa.tlbsrch_idx_i = idx;
    total_cnt++; if ({ifa.tlbsrch_en_o, ifa.done_o} !== 2'b00) $display("FAIL srch_wait: got %0h exp 0", {ifa.tlbsrch_en_o, ifa.done_o}); else pass_cnt++;
    step();
    ifa.tlbsrch_found_i = ~found; ifa.tlbsrch_idx_i = ~idx;
    total_cnt++; if ({ifa.done_o, ifa.wb_valid_o, ifa.wb_idx_we_o, ifa.wb_ehi_we_o, ifa.refetch_o, ifa.ine_o} !== 6'b111000)
      $display("FAIL srch_resp_flags: got %0h exp 38", {ifa.done_o, ifa.wb_valid_o, ifa.wb_idx_we_o, ifa.wb_ehi_we_o, ifa.refetch_o, ifa.ine_o}); else pass_cnt++;
    total_cnt++; if (ifa.wb_tlbidx_mask_o !== exp_mask) $display("FAIL srch_mask: got %0h exp %0h", ifa.wb_tlbidx_mask_o, exp_mask); else pass_cnt++;
    total_cnt++; if ((ifa.wb_tlbidx_o & exp_mask) !== exp_idx) $display("FAIL srch_tlbidx: got %0h exp %0h", ifa.wb_tlbidx_o & exp_mask, exp_idx); else pass_cnt++;
    step();
    ifa.tlbsrch_found_i = 0; ifa.tlbsrch_idx_i = 0;
    total_cnt++; if ({ifa.done_o, ifa.wb_valid_o, ifa.req_ready_o} !== 3'b001) $display("FAIL srch_after: got %0h exp 1", {ifa.done_o, ifa.wb_valid_o, ifa.req_ready_o}); else pass_cnt++;
  endtask

  task automatic test_rd(input logic [31:0] idx_in, input logic [31:0] exp_idx,
                         input logic [31:0] exp_ehi, input logic [31:0] exp_elo0,
                         input logic [31:0] exp_elo1, input logic [9:0] exp_asid);
    drive_req(3'd1, 5'd0, 10'd0, 19'd0);
    step();
    ifa.req_valid_i = 0;
    $display("txn rd tlbidx=%08h", idx_in);
    total_cnt++; if ({ifa.tlbrd_en_o, ifa.tlbsrch_en_o} !== 2'b10) $display("FAIL rd_strobe: got %0h exp 2", {ifa.tlbrd_en_o, ifa.tlbsrch_en_o}); else pass_cnt++;
    step();
    ifa.tlbidx_i = idx_in; ifa.tlbehi_i = 32'hABCD_E000; ifa.tlbelo0_i = 32'h0000_0011;
    ifa.tlbelo1_i = 32'h0000_0022; ifa.tlbasid_i = 10'h02A;
    step();
    ifa.tlbidx_i = 0; ifa.tlbehi_i = 0; ifa.tlbelo0_i = 0; ifa.tlbelo1_i = 0; ifa.tlbasid_i = 0;
    total_cnt++; if ({ifa.done_o, ifa.wb_valid_o, ifa.wb_idx_we_o, ifa.wb_ehi_we_o, ifa.wb_elo_we_o, ifa.wb_asid_we_o, ifa.refetch_o} !== 7'b1111110)
      $display("FAIL rd_flags: got %0h exp 7e", {ifa.done_o, ifa.wb_valid_o, ifa.wb_idx_we_o, ifa.wb_ehi_we_o, ifa.wb_elo_we_o, ifa.wb_asid_we_o, ifa.refetch_o}); else pass_cnt++;
    total_cnt++; if (ifa.wb_tlbidx_mask_o !== 32'hBF00_0000) $display("FAIL rd_mask: got %0h exp bf000000", ifa.wb_tlbidx_mask_o); else pass_cnt++;
    total_cnt++; if ((ifa.wb_tlbidx_o & 32'hBF00_0000) !== exp_idx) $display("FAIL rd_tlbidx: got %0h exp %0h", ifa.wb_tlbidx_o & 32'hBF00_0000, exp_idx); else pass_cnt++;
    total_cnt++; if ({ifa.wb_tlbehi_o, ifa.wb_tlbelo0_o, ifa.wb_tlbelo1_o, ifa.wb_asid_o} !== {exp_ehi, exp_elo0, exp_elo1, exp_asid})
      $display("FAIL rd_data: got %0h exp %0h", {ifa.wb_tlbehi_o, ifa.wb_tlbelo0_o, ifa.wb_tlbelo1_o, ifa.wb_asid_o}, {exp_ehi, exp_elo0, exp_elo1, exp_asid}); else pass_cnt++;
    step();
  endtask

  task automatic test_wr();
    drive_req(3'd2, 5'd0, 10'd0, 19'd0);
    step();
    ifa.req_valid_i = 0;
    $display("txn wr");
    total_cnt++; if ({ifa.tlbsrch_en_o, ifa.tlbrd_en_o, ifa.tlbwr_en_o, ifa.tlbfill_en_o, ifa.invtlb_en_o} !== 5'b00100)
      $display("FAIL wr_strobe: got %0h exp 4", {ifa.tlbsrch_en_o, ifa.tlbrd_en_o, ifa.tlbwr_en_o, ifa.tlbfill_en_o, ifa.invtlb_en_o}); else pass_cnt++;
    step();
    total_cnt++; if ({ifa.tlbwr_en_o, ifa.done_o, ifa.refetch_o, ifa.ine_o, ifa.wb_valid_o} !== 5'b01100)
      $display("FAIL wr_done: got %0h exp c", {ifa.tlbwr_en_o, ifa.done_o, ifa.refetch_o, ifa.ine_o, ifa.wb_valid_o}); else pass_cnt++;
    step();
  endtask

  task automatic test_fill();
    rst = 1;
    step();
    rst = 0;
    repeat (40) step();
    drive_req(3'd3, 5'd0, 10'd0, 19'd0);
    step();
    ifa.req_valid_i = 0;
    $display("txn fill at cycle 40");
    total_cnt++; if ({ifa.tlbfill_en_o, ifa.tlbwr_en_o} !== 2'b10) $display("FAIL fill_strobe: got %0h exp 2", {ifa.tlbfill_en_o, ifa.tlbwr_en_o}); else pass_cnt++;
    total_cnt++; if (ifa.rand_idx_o !== 5'd8) $display("FAIL fill_rand_idx: got %0d exp 8", ifa.rand_idx_o); else pass_cnt++;
    step();
    total_cnt++; if ({ifa.tlbfill_en_o, ifa.done_o, ifa.refetch_o, ifa.ine_o} !== 4'b0110)
      $display("FAIL fill_done: got %0h exp 6", {ifa.tlbfill_en_o, ifa.done_o, ifa.refetch_o, ifa.ine_o}); else pass_cnt++;
    repeat (5) step();
    total_cnt++; if (ifa.rand_idx_o !== 5'd8) $display("FAIL fill_rand_hold: got %0d exp 8", ifa.rand_idx_o); else pass_cnt++;
  endtask

  task automatic test_inv();
    drive_req(3'd4, 5'd5, 10'h03A, 19'h12345);
    step();
    drive_req(3'd4, 5'd1, 10'h3FF, 19'h7FFFF);
    ifa.req_valid_i = 0;
    $display("txn inv op=5 asid=3a vpn=12345");
    total_cnt++; if ({ifa.invtlb_en_o, ifa.tlbwr_en_o} !== 2'b10) $display("FAIL inv_strobe: got %0h exp 2", {ifa.invtlb_en_o, ifa.tlbwr_en_o}); else pass_cnt++;
    total_cnt++; if ({ifa.invtlb_op_o, ifa.invtlb_asid_o, ifa.invtlb_vpn_o} !== {5'd5, 10'h03A, 19'h12345})
      $display("FAIL inv_operands: got %0h exp %0h", {ifa.invtlb_op_o, ifa.invtlb_asid_o, ifa.invtlb_vpn_o}, {5'd5, 10'h03A, 19'h12345}); else pass_cnt++;
    step();
    total_cnt++; if ({ifa.invtlb_en_o, ifa.done_o, ifa.refetch_o, ifa.ine_o} !== 4'b0110)
      $display("FAIL inv_done: got %0h exp 6", {ifa.invtlb_en_o, ifa.done_o, ifa.refetch_o, ifa.ine_o}); else pass_cnt++;
    step();
  endtask

  task automatic test_illegal(input logic [2:0] op, input logic [4:0] invop);
    drive_req(op, invop, 10'h001, 19'h1);
    step();
    ifa.req_valid_i = 0;
    $display("txn illegal op=%0d invop=%0d", op, invop);
    total_cnt++; if ({ifa.done_o, ifa.ine_o, ifa.refetch_o, ifa.req_ready_o} !== 4'b1100)
      $display("FAIL illegal_done: got %0h exp c", {ifa.done_o, ifa.ine_o, ifa.refetch_o, ifa.req_ready_o}); else pass_cnt++;
    total_cnt++; if ({ifa.tlbsrch_en_o, ifa.tlbrd_en_o, ifa.tlbwr_en_o, ifa.tlbfill_en_o, ifa.invtlb_en_o} !== 5'b0)
      $display("FAIL illegal_strobe: got %0h exp 0", {ifa.tlbsrch_en_o, ifa.tlbrd_en_o, ifa.tlbwr_en_o, ifa.tlbfill_en_o, ifa.invtlb_en_o}); else pass_cnt++;
    step();
    total_cnt++; if ({ifa.done_o, ifa.ine_o, ifa.req_ready_o, ifa.invtlb_en_o} !== 4'b0010)
      $display("FAIL illegal_after: got %0h exp 2", {ifa.done_o, ifa.ine_o, ifa.req_ready_o, ifa.invtlb_en_o}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive_req(3'd2, 5'd0, 10'd0, 19'd0);
    step();
    ifa.req_op_i = 3'd0;
    $display("txn back-to-back wr then srch");
    total_cnt++; if ({ifa.tlbwr_en_o, ifa.req_ready_o} !== 2'b10) $display("FAIL b2b_issue: got %0h exp 2", {ifa.tlbwr_en_o, ifa.req_ready_o}); else pass_cnt++;
    step();
    total_cnt++; if ({ifa.done_o, ifa.req_ready_o, ifa.tlbsrch_en_o} !== 3'b100) $display("FAIL b2b_resp: got %0h exp 4", {ifa.done_o, ifa.req_ready_o, ifa.tlbsrch_en_o}); else pass_cnt++;
    step();
    total_cnt++; if ({ifa.done_o, ifa.req_ready_o, ifa.tlbsrch_en_o} !== 3'b010) $display("FAIL b2b_idle: got %0h exp 2", {ifa.done_o, ifa.req_ready_o, ifa.tlbsrch_en_o}); else pass_cnt++;
    step();
    ifa.req_valid_i = 0;
    total_cnt++; if ({ifa.tlbsrch_en_o, ifa.req_ready_o} !== 2'b10) $display("FAIL b2b_second: got %0h exp 2", {ifa.tlbsrch_en_o, ifa.req_ready_o}); else pass_cnt++;
    step();
    step();
    total_cnt++; if ({ifa.done_o, ifa.wb_valid_o, ifa.refetch_o, ifa.wb_tlbidx_mask_o} !== {3'b110, 32'h8000_0000})
      $display("FAIL b2b_srch_done: got %0h exp %0h", {ifa.done_o, ifa.wb_valid_o, ifa.refetch_o, ifa.wb_tlbidx_mask_o}, {3'b110, 32'h8000_0000}); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_wait();
    ifb.req_valid_i = 1; ifb.req_op_i = 3'd0;
    step();
    ifb.req_valid_i = 0;
    $display("txn srch on RSP_LAT=3 with reset in WAIT");
    total_cnt++; if (ifb.tlbsrch_en_o !== 1'b1) $display("FAIL rstw_strobe: got %0h exp 1", ifb.tlbsrch_en_o); else pass_cnt++;
    step();
    step();
    rst_b = 1; ifb.tlbsrch_found_i = 1; ifb.tlbsrch_idx_i = 5'd7;
    step();
    rst_b = 0;
    total_cnt++; if (ifb.req_ready_o !== 1'b1) $display("FAIL rstw_ready: got %0h exp 1", ifb.req_ready_o); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if ({ifb.done_o, ifb.wb_valid_o} !== 2'b00) $display("FAIL rstw_no_done: cycle %0d got %0h exp 0", i, {ifb.done_o, ifb.wb_valid_o}); else pass_cnt++;
      step();
    end
    ifb.tlbsrch_found_i = 0; ifb.tlbsrch_idx_i = 0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1; rst_b = 1;
    clear_inputs();
    step();
    test_reset();
    test_srch(1'b1, 5'd13, 32'h0000_000D, 32'h8000_001F);
    test_srch(1'b0, 5'd13, 32'h8000_0000, 32'h8000_0000);
    test_rd(32'h8C00_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 10'h0);
    test_rd(32'h1500_0000, 32'h1500_0000, 32'hABCD_E000, 32'h11, 32'h22, 10'h02A);
    test_wr();
    test_fill();
    test_inv();
    test_illegal(3'd4, 5'd7);
    test_illegal(3'd6, 5'd0);
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/tlb_op_unit.md
# tlb_op_unit

Sequencer for the privileged TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB), sitting directly upstream of the memory management unit. It accepts one committed TLB instruction at a time and drives the MMU's single-cycle maintenance strobes. It waits for the registered TLB response, then returns a masked CSR write-back packet plus a done/refetch indication to the commit stage. It also owns the free-running random index used by TLBFILL.

## Interface
- `TLB_ENTRY_NUM`, 32: number of TLB entries; `IDX_W = $clog2(TLB_ENTRY_NUM)`.
- `RSP_LAT`, 1: cycles from an MMU search/read strobe to a valid response; legal range 1..3.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  commit stage presents a TLB instruction.
- `req_ready_o`  out  1  unit idle and able to accept.
- `req_op_i`  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5..7 illegal.
- `req_invop_i`  in  5  INVTLB op field.
- `req_asid_i`  in  10  INVTLB asid operand.
- `req_vpn_i`  in  19  INVTLB vpn operand.
- `tlbsrch_en_o`, `tlbrd_en_o`, `tlbwr_en_o`, `tlbfill_en_o`, `invtlb_en_o`  out  1 each  one-cycle MMU strobes.
- `invtlb_op_o` / `invtlb_asid_o` / `invtlb_vpn_o`  out  5/10/19  INVTLB operands, held stable while `invtlb_en_o` is high.
- `rand_idx_o`  out  `IDX_W`  fill index.
- `tlbsrch_found_i` / `tlbsrch_idx_i`  in  1/`IDX_W`  search result.
- `tlbehi_i`, `tlbelo0_i`, `tlbelo1_i`, `tlbidx_i`  in  32 each  read result.
- `tlbasid_i`  in  10  read result.
- `wb_valid_o`  out  1  one-cycle CSR write-back strobe.
- `wb_idx_we_o`, `wb_ehi_we_o`, `wb_elo_we_o`, `wb_asid_we_o`  out  1 each  per-CSR write enables.
- `wb_tlbidx_o`  out  32  TLBIDX write value.
- `wb_tlbidx_mask_o`  out  32  bits of TLBIDX to be written.
- `wb_tlbehi_o`, `wb_tlbelo0_o`, `wb_tlbelo1_o`  out  32 each  write values.
- `wb_asid_o`  out  10  write value.
- `done_o`  out  1  instruction complete (one-cycle pulse).
- `refetch_o`  out  1  with `done_o`; pipeline must refetch from the next PC.
- `ine_o`  out  1  with `done_o`; illegal op or INVTLB op > 6.

## Operation
- **FSM:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch op and operands, then go to ISSUE.
  - An illegal `req_op_i` or an INVTLB with invop > 6 goes straight to RESP with `ine_o`. No strobe is issued.
- **ISSUE (1 cycle):**
  - Assert exactly one strobe matching the latched op.
  - SRCH and RD go to WAIT.
  - WR, FILL and INV go to RESP.
- **WAIT:** count `RSP_LAT` cycles. In the last WAIT cycle, capture the MMU response into registers, then go to RESP.
- **RESP (1 cycle):**
  - Assert `done_o`.
  - For SRCH/RD, also assert `wb_valid_o` and the enables below.
  - Return to IDLE.
- **SRCH write-back:** `wb_idx_we_o`=1.
  - Found: NE (bit 31) is cleared and INDEX[`IDX_W`-1:0] is set to the index. Mask = bit 31 | INDEX bits.
  - Not found: NE=1. Mask = bit 31 only; INDEX is unchanged.
- **RD write-back, entry exists (`tlbidx_i[31]`=0):**
  - All four enables are set.
  - TLBIDX mask = bit 31 | bits 29:24 (PS), values taken from `tlbidx_i`.
  - EHI, ELO0, ELO1 and ASID are copied from the inputs.
- **RD write-back, entry absent:**
  - NE=1 and PS=0 (same mask as the exists case).
  - EHI, ELO0 and ELO1 are written 0; ASID is written 0.
- **refetch_o:** 1 for WR, FILL and INV, including INV ops 0..6. It is 0 for SRCH, RD and any `ine_o` completion.
- **Random index:**
  - `IDX_W`-bit counter, incremented every cycle; wraps from max to 0.
  - The counter value is frozen into `rand_idx_o` at the IDLE→ISSUE transition of a FILL.
  - `rand_idx_o` is held until the next FILL.
- **Back-to-back:** no overlap of instructions. A new request is accepted only in IDLE, so the earliest next accept is the cycle after RESP.

## Timing
- **Reset:**
  - State IDLE, counter 0.
  - All strobes, `wb_*`, `done_o`, `refetch_o`, `ine_o`, `rand_idx_o` and the invtlb operands are 0.
  - `req_ready_o`=1.
- **Latency, counting the accept cycle as T:**
  - WR, FILL, INV: strobe at T+1, `done_o` at T+2.
  - SRCH, RD: strobe at T+1, capture at T+1+`RSP_LAT`, `done_o`/`wb_valid_o` at T+2+`RSP_LAT`.
  - Illegal: `done_o`+`ine_o` at T+1.
- All outputs are registered; no combinational path from `req_*` to any output except `req_ready_o`, which is state-only.
- **Reset mid-operation:** abandons the instruction. No strobe, write-back or done is produced after the reset cycle.
- **MMU inputs:** sampled only in the capture cycle and ignored otherwise.

## Test plan
- **SRCH hit:** op=0 with `tlbsrch_found_i`=1, idx=13 at the capture cycle → at T+3, `wb_tlbidx_o`[4:0]=13, bit31=0, mask=0x8000001F, `refetch_o`=0.
- **RD absent:** `tlbidx_i`=0x8C000000 → mask 0xBF000000, NE=1, PS=0; EHI, ELO0, ELO1 and ASID all written 0.
- **FILL:** accept at cycle 40 after reset → `rand_idx_o`=8 (40 mod 32), `tlbfill_en_o` for exactly one cycle, `done_o`+`refetch_o` at T+2.
- **INV op=5:** asid=0x3A, vpn=0x12345 → `invtlb_en_o` one cycle with operands stable. INV op=7 → no strobe, `ine_o`+`done_o` at T+1.
- **Back-to-back:** `req_valid_i` held high for WR then SRCH → `req_ready_o` low during ISSUE through RESP; the second accept lands the cycle after the first `done_o`.
- **Reset mid-WAIT:** with `RSP_LAT`=3, assert `rst` in the second WAIT cycle → no `wb_valid_o`/`done_o`, and `req_ready_o`=1 the next cycle.
